// File: rtl/stoch_decode_mat.sv
// Element-wise stochastic-to-binary decoder: counts ones per element over a
// window of 2^WINDOW_BITS enabled samples and publishes the counts with a strobe.
module stoch_decode_mat #(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_COLS    = 2,
  parameter int WINDOW_BITS = 8,
  localparam int N          = NUM_ROWS * NUM_COLS,
  localparam int CW         = WINDOW_BITS + 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            EN,
  input  logic            CLR,
  input  logic [N-1:0]    X,
  output logic [N*CW-1:0] Y,
  output logic            VALID,
  output logic            BUSY
);

  // VALID is a one-cycle strobe with no ready: Y carries a completed window on
  // the cycle VALID=1 and is held afterwards until the next window completes.
  logic [WINDOW_BITS-1:0] cnt_q, cnt_d;
  logic [CW-1:0]          acc_q [N];
  logic [CW-1:0]          acc_d [N];
  logic [N*CW-1:0]        y_q, y_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   last_sample;

  assign last_sample = EN && (cnt_q == {WINDOW_BITS{1'b1}});

  always_comb begin
    cnt_d   = cnt_q;
    y_d     = y_q;
    valid_d = 1'b0;
    for (int k = 0; k < N; k++) acc_d[k] = acc_q[k];

    if (CLR) begin
      cnt_d = '0;
      for (int k = 0; k < N; k++) acc_d[k] = '0;
    end else if (EN) begin
      cnt_d = cnt_q + 1'b1;
      for (int k = 0; k < N; k++) begin
        // The final sample is folded straight into Y so the next window starts clean.
        if (last_sample) begin
          y_d[k*CW +: CW] = acc_q[k] + {{(CW-1){1'b0}}, X[k]};
          acc_d[k]        = '0;
        end else begin
          acc_d[k] = acc_q[k] + {{(CW-1){1'b0}}, X[k]};
        end
      end
      valid_d = last_sample;
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < N; k++) acc_q[k] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      for (int k = 0; k < N; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign Y     = y_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;

endmodule
